// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state codes and debounce defaults.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } timer_state_t;

    // 20 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, registered press pulse.
module key_debounce
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    primed;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_prev;

    // A key held through reset must be seen released before it can generate a press;
    // primed marks when the synchronizer holds real samples rather than reset values.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            sync       <= '1;
            primed     <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b1;
            level_prev <= 1'b1;
            press      <= 1'b0;
        end else begin
            sync   <= {sync[0], key_n};
            primed <= {primed[0], 1'b1};
            if (primed[1] && sync[1]) begin
                armed <= 1'b1;
            end

            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end

            level_prev <= level;
            press      <= armed && level_prev && !level;
        end
    end

endmodule

// File: rtl/timer_key_ctrl.sv
// Start/pause and clear key handling plus the run-control FSM for the countdown timer.
module timer_key_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic [2:1] key_n,
    input  logic       tick,
    input  logic       zero,
    output logic       count_en,
    output logic       clear_n,
    output logic [1:0] state,
    output logic       expired
);

    logic         start_press;
    logic         clear_press;
    timer_state_t state_q;
    timer_state_t state_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .Clk   (Clk),
        .rst   (rst),
        .key_n (key_n[1]),
        .press (start_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .Clk   (Clk),
        .rst   (rst),
        .key_n (key_n[2]),
        .press (clear_press)
    );

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_press) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_press) state_d = RUNNING;
                RUNNING: begin
                    if (zero) begin
                        state_d = EXPIRED;
                    end else if (start_press) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED:  if (start_press) state_d = RUNNING;
                EXPIRED: state_d = EXPIRED;
            endcase
        end
    end

    // Gating on zero keeps the downstream counter from stepping below 00.
    always_comb begin
        count_en = tick && (state_q == RUNNING) && !zero;
        clear_n  = (state_q != IDLE);
        expired  = (state_q == EXPIRED);
        state    = state_q;
    end

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Table-driven bench for timer_key_ctrl with DEBOUNCE_CYCLES=4 and an expected-output queue.
module tb_timer_key_ctrl;

    logic       Clk;
    logic       rst;
    logic [2:1] key_n;
    logic       tick;
    logic       zero;
    logic       count_en;
    logic       clear_n;
    logic [1:0] state;
    logic       expired;

    timer_key_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .Clk      (Clk),
        .rst      (rst),
        .key_n    (key_n),
        .tick     (tick),
        .zero     (zero),
        .count_en (count_en),
        .clear_n  (clear_n),
        .state    (state),
        .expired  (expired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [2:1] key_n;
        logic       tick;
        logic       zero;
        logic [1:0] st;
        int         grp;
    } vec_t;

    typedef struct {
        logic       ce;
        logic       cn;
        logic [1:0] st;
        logic       ex;
        int         id;
        int         grp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   step_no = 0;
    int   grp = 0;

    task automatic add(input int n, input logic r, input logic [2:1] k,
                       input logic t, input logic z, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.key_n = k; v.tick = t; v.zero = z; v.st = st; v.grp = grp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check_front();
        exp_t e;
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard step %0d: got empty queue, want an expected entry", step_no);
        end else begin
            e = sb.pop_front();
            if (count_en === e.ce && clear_n === e.cn && state === e.st && expired === e.ex) begin
                pass_cnt++;
            end else begin
                $display("FAIL outputs step %0d grp %0d: got ce=%0b cn=%0b st=%0d ex=%0b, want ce=%0b cn=%0b st=%0d ex=%0b",
                         e.id, e.grp, count_en, clear_n, state, expired, e.ce, e.cn, e.st, e.ex);
            end
        end
    endtask

    // Expected outputs follow from the expected state and the inputs of that cycle.
    task automatic step(input logic r, input logic [2:1] k, input logic t,
                        input logic z, input logic [1:0] st);
        exp_t e;
        @(posedge Clk);
        #1;
        rst = r; key_n = k; tick = t; zero = z;
        e.ce = t && (st == 2'd1) && !z;
        e.cn = (st != 2'd0);
        e.st = st;
        e.ex = (st == 2'd3);
        e.id = step_no;
        e.grp = grp;
        sb.push_back(e);
        @(negedge Clk);
        check_front();
        step_no++;
    endtask

    task automatic steps(input int n, input logic r, input logic [2:1] k,
                         input logic t, input logic z, input logic [1:0] st);
        for (int i = 0; i < n; i++) step(r, k, t, z, st);
    endtask

    initial begin
        rst = 1'b0; key_n = 2'b11; tick = 1'b0; zero = 1'b0;
        repeat (2) @(posedge Clk);

        grp = 1; // reset state, tick ignored
        add(2, 0, 2'b11, 1, 0, 0);
        add(5, 1, 2'b11, 0, 0, 0);

        grp = 2; // start key bouncing every 2 cycles: no event
        for (int i = 0; i < 10; i++) begin
            add(1, 1, 2'b10, 1, 0, 0);
            add(1, 1, 2'b10, 0, 0, 0);
            add(2, 1, 2'b11, 0, 0, 0);
        end
        add(6, 1, 2'b11, 0, 0, 0);

        grp = 3; // start press: pulse 7 cycles after edge, tick in pulse cycle ignored
        add(7, 1, 2'b10, 0, 0, 0);
        add(1, 1, 2'b10, 1, 0, 0);
        add(2, 1, 2'b10, 0, 0, 1);

        grp = 4; // five ticks while running
        for (int i = 0; i < 5; i++) begin
            add(1, 1, 2'b11, 1, 0, 1);
            add(1, 1, 2'b11, 0, 0, 1);
        end
        add(2, 1, 2'b11, 0, 0, 1);

        grp = 5; // start press -> PAUSED, ticks then blocked
        add(7, 1, 2'b10, 0, 0, 1);
        add(1, 1, 2'b10, 1, 0, 1);
        add(1, 1, 2'b10, 1, 0, 2);
        add(1, 1, 2'b10, 0, 0, 2);

        grp = 6; // paused: zero and tick ignored
        for (int i = 0; i < 5; i++) begin
            add(1, 1, 2'b11, 1, 1, 2);
            add(1, 1, 2'b11, 0, 0, 2);
        end
        add(2, 1, 2'b11, 0, 0, 2);

        grp = 7; // resume
        add(8, 1, 2'b10, 0, 0, 2);
        add(2, 1, 2'b10, 0, 0, 1);
        add(12, 1, 2'b11, 0, 0, 1);

        grp = 8; // zero with tick: no strobe, EXPIRED next edge
        add(1, 1, 2'b11, 1, 1, 1);
        add(1, 1, 2'b11, 1, 1, 3);
        add(2, 1, 2'b11, 0, 1, 3);

        grp = 9; // start presses ignored in EXPIRED
        add(10, 1, 2'b10, 1, 1, 3);
        add(10, 1, 2'b11, 0, 1, 3);

        grp = 10; // clear from EXPIRED
        add(8, 1, 2'b01, 0, 1, 3);
        add(2, 1, 2'b01, 0, 0, 0);
        add(12, 1, 2'b11, 0, 0, 0);

        grp = 11; // IDLE -> RUNNING -> PAUSED
        add(8, 1, 2'b10, 0, 0, 0);
        add(2, 1, 2'b10, 0, 0, 1);
        add(12, 1, 2'b11, 0, 0, 1);
        add(8, 1, 2'b10, 0, 0, 1);
        add(2, 1, 2'b10, 0, 0, 2);
        add(12, 1, 2'b11, 0, 0, 2);

        grp = 12; // start and clear together from PAUSED -> IDLE
        add(8, 1, 2'b00, 0, 0, 2);
        add(2, 1, 2'b00, 0, 0, 0);
        add(12, 1, 2'b11, 0, 0, 0);

        grp = 13; // clear overrides zero in RUNNING
        add(8, 1, 2'b10, 0, 0, 0);
        add(2, 1, 2'b10, 0, 0, 1);
        add(12, 1, 2'b11, 0, 0, 1);
        add(7, 1, 2'b01, 0, 0, 1);
        add(1, 1, 2'b01, 1, 1, 1);
        add(2, 1, 2'b01, 0, 0, 0);
        add(12, 1, 2'b11, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            grp = vecs[i].grp;
            step(vecs[i].rst, vecs[i].key_n, vecs[i].tick, vecs[i].zero, vecs[i].st);
        end

        grp = 14; // reset mid-debounce while RUNNING, key held across reset release
        steps(8, 1, 2'b10, 0, 0, 0);
        steps(2, 1, 2'b10, 0, 0, 1);
        steps(12, 1, 2'b11, 0, 0, 1);
        steps(3, 1, 2'b10, 0, 0, 1);
        step(0, 2'b10, 0, 0, 1);
        step(0, 2'b10, 1, 0, 0);
        steps(14, 1, 2'b10, 1, 0, 0);
        steps(12, 1, 2'b11, 0, 0, 0);

        grp = 15; // re-press after release is accepted
        steps(8, 1, 2'b10, 0, 0, 0);
        step(1, 2'b10, 1, 0, 1);
        step(1, 2'b10, 0, 0, 1);
        steps(6, 1, 2'b11, 0, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
